div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
- Sits beside the EX stage, which issues operands, stalls the pipeline until ready_o is high, then forwards result_o down the MEM/WB path into the HI/LO register file.
- result_o[63:32] is the remainder (the HI value); result_o[31:0] is the quotient (the LO value).

Parameters:
- DATA_W, 32, operand width in bits; fixed at 32 for this ISA.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset rst, synchronous, active-high.
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request; held high by EX until ready_o is seen.
- annul_i  input  1  cancel; driven by flush/exception.
- result_o  output  64  {remainder, quotient}; registered.
- ready_o  output  1  result valid; registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= FREE, cnt <= 0, result_o <= 0, ready_o <= 0.
  - Reset has priority over every other input in every state, including mid-division.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON; at the same edge:
    - cnt <= 0.
    - Latch the divisor, the absolute value of the dividend, and the two sign bits.
    - Absolute values are taken only when signed_div_i=1 and the operand MSB=1.
    - The partial remainder is cleared.
  - Otherwise stay in FREE.
  - ready_o=0 and result_o=0 throughout.
- ON, one iteration per edge:
  - diff = {partial_rem[31:0], dividend_msb} - {1'b0, |divisor|}, computed at 33 bits.
  - diff[32]=1 (borrow): shift the dividend bit in; quotient bit = 0.
  - No borrow: partial_rem <= diff; quotient bit = 1.
  - cnt increments each iteration.
  - When cnt reaches 32, do the sign fix-up instead of another iteration:
    - Negate the quotient if signed and sign1 XOR sign2.
    - Negate the remainder if signed and sign1 (the remainder takes the dividend's sign).
  - At that same edge: result_o <= {rem, quo}, ready_o <= 1, state <= END.
  - annul_i=1 in ON -> FREE at the next edge; cnt <= 0; no result or ready is produced.
- BYZERO: next edge -> END, result_o <= 0, ready_o <= 1. MIPS leaves HI/LO undefined here; we define them as 0.
- END:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0 -> FREE; ready_o <= 0 and result_o <= 0 at that edge.
- Latency:
  - Normal division: ready_o is visible after 33 edges counted from the edge that samples start_i.
  - Divide by zero: ready_o is visible after 2 edges.
- Corner cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps naturally, no trap).
  - Operand changes while in ON are ignored, because operands are latched at start.
  - start_i held high through END does not retrigger; a new operation requires FREE.
  - annul_i is ignored in END and BYZERO.

Decomposition:
- Shared constants go in define.v:
  - DivFree, DivByZero, DivOn, DivEnd.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
- No sub-module is needed. The per-iteration 33-bit subtract is inline combinational logic in a single file.

Test Plan:
- DIVU 100/7: start pulse held -> ready_o rises 33 edges after the start sample; result_o = 0x00000002_0000000E. Drop start -> ready_o=0 next edge.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero, DIVU 5/0 -> ready_o after 2 edges; result_o = 0.
- Boundary values:
  - DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- annul_i at the 10th ON iteration -> state FREE next edge; ready_o never asserts. Immediate new DIVU 9/3 -> 0x00000000_00000003 after 33 edges.
- rst=1 mid-ON (iteration 20) -> next edge state FREE, result_o=0, ready_o=0. rst held together with start_i=1 -> stays in FREE.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants and state encoding for the MIPS DIV/DIVU unit
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // Two's-complement magnitude, applied only for signed operands with the MSB set.
    function automatic logic [DIV_DATA_W-1:0] abs_if_neg(input logic is_signed,
                                                         input logic [DIV_DATA_W-1:0] v);
        return (is_signed && v[DIV_DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage to divider handshake and operand bundle
interface div_unit_if;
    import div_unit_pkg::*;

    logic                      signed_div_i;
    logic [DIV_DATA_W-1:0]     opdata1_i;
    logic [DIV_DATA_W-1:0]     opdata2_i;
    logic                      start_i;
    logic                      annul_i;
    logic [2*DIV_DATA_W-1:0]   result_o;
    logic                      ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider, one quotient bit per cycle, {rem, quo} result
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  dvd;
    logic [DATA_W-1:0]  dvs;
    logic [DATA_W-1:0]  rem;
    logic               sgn;
    logic               sign1;
    logic               sign2;

    logic [DATA_W:0]    diff;
    logic               borrow;
    logic [DATA_W-1:0]  rem_nxt;
    logic [DATA_W-1:0]  quo_nxt;
    logic [DATA_W-1:0]  rem_fix;
    logic [DATA_W-1:0]  quo_fix;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last_iter;

    // The dividend register doubles as the quotient: each iteration shifts out a
    // dividend bit at the top and shifts the new quotient bit in at the bottom.
    assign diff      = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
    assign borrow    = diff[DATA_W];
    assign rem_nxt   = borrow ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : diff[DATA_W-1:0];
    assign quo_nxt   = {dvd[DATA_W-2:0], ~borrow};
    assign cnt_nxt   = cnt + 1'b1;
    assign last_iter = (cnt_nxt == CNT_W'(DATA_W));

    // The final iteration and the sign fix-up share one edge, so the remainder
    // takes the dividend's sign and the quotient the XOR of both signs.
    assign quo_fix = (sgn && (sign1 ^ sign2)) ? (~quo_nxt + 1'b1) : quo_nxt;
    assign rem_fix = (sgn && sign1) ? (~rem_nxt + 1'b1) : rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DIV_FREE;
            cnt          <= '0;
            dvd          <= '0;
            dvs          <= '0;
            rem          <= '0;
            sgn          <= 1'b0;
            sign1        <= 1'b0;
            sign2        <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    bus.result_o <= '0;
                    bus.ready_o  <= DIV_RESULT_NOT_READY;
                    if (bus.start_i == DIV_START && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state <= DIV_ON;
                            cnt   <= '0;
                            sgn   <= bus.signed_div_i;
                            sign1 <= bus.opdata1_i[DATA_W-1];
                            sign2 <= bus.opdata2_i[DATA_W-1];
                            dvd   <= abs_if_neg(bus.signed_div_i, bus.opdata1_i);
                            dvs   <= abs_if_neg(bus.signed_div_i, bus.opdata2_i);
                            rem   <= '0;
                        end
                    end
                end
                DIV_BYZERO: begin
                    state        <= DIV_END;
                    bus.result_o <= '0;
                    bus.ready_o  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        state <= DIV_FREE;
                        cnt   <= '0;
                    end else begin
                        dvd <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt_nxt;
                        if (last_iter) begin
                            state        <= DIV_END;
                            bus.result_o <= {rem_fix, quo_fix};
                            bus.ready_o  <= DIV_RESULT_READY;
                        end
                    end
                end
                DIV_END: begin
                    if (bus.start_i == DIV_STOP) begin
                        state        <= DIV_FREE;
                        cnt          <= '0;
                        bus.result_o <= '0;
                        bus.ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sd, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sd;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
    endtask

    // Start held until ready, operands scrambled after the start sample, one extra
    // held cycle to confirm END holds, then start dropped to return to FREE.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        drive(sd, a, b);
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick();
            if (i == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sd;
            end
            if (bus.ready_o === 1'b1) lat = i;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, bus.result_o, exp);
        tick();
        chk({tag, " hold ready"}, {63'b0, bus.ready_o}, 64'd1);
        chk({tag, " hold result"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        tick();
        chk({tag, " drop ready"}, {63'b0, bus.ready_o}, 64'd0);
        chk({tag, " drop result"}, bus.result_o, 64'd0);
        chk({tag, " drop state"}, {62'b0, dut.state}, {62'b0, DIV_FREE});
    endtask

    initial begin
        logic any_ready;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        tick();
        tick();
        chk("reset ready", {63'b0, bus.ready_o}, 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        chk("reset state", {62'b0, dut.state}, {62'b0, DIV_FREE});
        rst = 1'b0;
        tick();

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("div 7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
        run_div("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_div("divu max/max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33);
        run_div("divu 7/9", 1'b0, 32'd7, 32'd9, 64'h00000007_00000000, 33);

        // Annul during the 10th iteration, then an immediate fresh division.
        any_ready = 1'b0;
        drive(1'b0, 32'd1000, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            tick();
            any_ready = any_ready | bus.ready_o;
        end
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        any_ready = any_ready | bus.ready_o;
        chk("annul state", {62'b0, dut.state}, {62'b0, DIV_FREE});
        chk("annul no ready", {63'b0, any_ready}, 64'd0);
        chk("annul result", bus.result_o, 64'd0);
        run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Reset during the 20th iteration, then reset held alongside start.
        drive(1'b1, 32'd100, 32'd7);
        for (int i = 1; i <= 20; i++) tick();
        chk("mid-on state", {62'b0, dut.state}, {62'b0, DIV_ON});
        rst = 1'b1;
        tick();
        chk("rst mid-on state", {62'b0, dut.state}, {62'b0, DIV_FREE});
        chk("rst mid-on ready", {63'b0, bus.ready_o}, 64'd0);
        chk("rst mid-on result", bus.result_o, 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst+start state", {62'b0, dut.state}, {62'b0, DIV_FREE});
        chk("rst+start ready", {63'b0, bus.ready_o}, 64'd0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        tick();
        run_div("divu 100/7 after rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
